// File: rtl/tdm_mul_sched_if.sv
// Frame request, operand and result bundle for the time-division fixed-point multiplier.
// The scheduler attaches as slave; whoever issues frames attaches as master.
interface tdm_mul_sched_if #(
   parameter int C_WIDTH   = 32,
   parameter int NUM_UNITS = 32
);
   logic                           frame_start;
   logic [NUM_UNITS-1:0]           ch_enable;
   logic [C_WIDTH*NUM_UNITS-1:0]   multiplicands;
   logic [C_WIDTH*NUM_UNITS-1:0]   multipliers;
   logic [C_WIDTH*NUM_UNITS-1:0]   products;
   logic [NUM_UNITS-1:0]           ovf_flags;
   logic                           busy;
   logic                           frame_done;
   logic                           overrun;

   modport master (
      output frame_start, ch_enable, multiplicands, multipliers,
      input  products, ovf_flags, busy, frame_done, overrun
   );

   modport slave (
      input  frame_start, ch_enable, multiplicands, multipliers,
      output products, ovf_flags, busy, frame_done, overrun
   );
endinterface

// File: rtl/tdm_mul_sched.sv
// Time-division scheduler: one shared radix-2 shift-add multiplier walks the enabled
// channels of a frame, producing saturating signed fixed-point products per channel.
module tdm_mul_sched #(
   parameter int C_WIDTH     = 32,
   parameter int FIXED_POINT = 8,
   parameter int NUM_UNITS   = 32
) (
   input  logic           ctl_clk,
   input  logic           ctl_rst,
   tdm_mul_sched_if.slave bus
);
   localparam int IDX_W  = $clog2(NUM_UNITS);
   localparam int CNT_W  = $clog2(C_WIDTH + 1);
   localparam int PROD_W = 2 * C_WIDTH;
   localparam logic [PROD_W-1:0] MAX_MAG = (PROD_W'(1) << (C_WIDTH - 1)) - PROD_W'(1);

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CALC, ST_WRITE, ST_DONE} state_t;

   state_t               state_reg, state_next;
   logic [NUM_UNITS-1:0] mask_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [PROD_W-1:0]    mcand_reg;
   logic [C_WIDTH-1:0]   mplier_reg;
   logic [PROD_W-1:0]    acc_reg;
   logic                 neg_reg;
   logic [C_WIDTH-1:0]   prod_mem [NUM_UNITS];
   logic [NUM_UNITS-1:0] ovf_reg;
   logic                 frame_done_reg;
   logic                 overrun_reg;

   logic [C_WIDTH-1:0]   op_a_arr [NUM_UNITS];
   logic [C_WIDTH-1:0]   op_b_arr [NUM_UNITS];
   logic [C_WIDTH-1:0]   cur_a, cur_b, mag_a, mag_b;
   logic [PROD_W-1:0]    trunc_c;
   logic                 sat_c;
   logic [C_WIDTH-1:0]   mag_res, result_c;
   logic                 first_found, next_found;
   logic [IDX_W-1:0]     first_idx, next_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_UNITS; gi++) begin : g_ch
         assign op_a_arr[gi] = bus.multiplicands[gi*C_WIDTH +: C_WIDTH];
         assign op_b_arr[gi] = bus.multipliers[gi*C_WIDTH +: C_WIDTH];
         assign bus.products[gi*C_WIDTH +: C_WIDTH] = prod_mem[gi];
      end
   endgenerate

   assign bus.ovf_flags  = ovf_reg;
   assign bus.busy       = (state_reg != ST_IDLE);
   assign bus.frame_done = frame_done_reg;
   assign bus.overrun    = overrun_reg;

   // Descending scans so the lowest qualifying index is the one left standing.
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         if (bus.ch_enable[i]) begin
            first_found = 1'b1;
            first_idx   = IDX_W'(i);
         end
         if (mask_reg[i] && (i > int'(idx_reg))) begin
            next_found = 1'b1;
            next_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      cur_a    = op_a_arr[idx_reg];
      cur_b    = op_b_arr[idx_reg];
      mag_a    = cur_a[C_WIDTH-1] ? -cur_a : cur_a;
      mag_b    = cur_b[C_WIDTH-1] ? -cur_b : cur_b;
      trunc_c  = acc_reg >> FIXED_POINT;
      sat_c    = (trunc_c > MAX_MAG);
      mag_res  = sat_c ? MAX_MAG[C_WIDTH-1:0] : trunc_c[C_WIDTH-1:0];
      // Negating a zero magnitude stays zero, so a zero product is always positive.
      result_c = neg_reg ? -mag_res : mag_res;
   end

   always_ff @(posedge ctl_clk or negedge ctl_rst) begin
      if (!ctl_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (bus.frame_start) state_next = first_found ? ST_LOAD : ST_DONE;
         ST_LOAD:  state_next = ST_CALC;
         ST_CALC:  if (cnt_reg == CNT_W'(C_WIDTH - 1)) state_next = ST_WRITE;
         ST_WRITE: state_next = next_found ? ST_LOAD : ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge ctl_clk or negedge ctl_rst) begin
      if (!ctl_rst) begin
         mask_reg       <= '0;
         idx_reg        <= '0;
         cnt_reg        <= '0;
         mcand_reg      <= '0;
         mplier_reg     <= '0;
         acc_reg        <= '0;
         neg_reg        <= 1'b0;
         ovf_reg        <= '0;
         frame_done_reg <= 1'b0;
         overrun_reg    <= 1'b0;
         for (int i = 0; i < NUM_UNITS; i++) prod_mem[i] <= '0;
      end else begin
         frame_done_reg <= (state_reg == ST_DONE);
         overrun_reg    <= bus.frame_start && (state_reg != ST_IDLE);
         case (state_reg)
            ST_IDLE: begin
               if (bus.frame_start && first_found) begin
                  mask_reg <= bus.ch_enable;
                  idx_reg  <= first_idx;
               end
            end
            ST_LOAD: begin
               mcand_reg  <= {{C_WIDTH{1'b0}}, mag_a};
               mplier_reg <= mag_b;
               acc_reg    <= '0;
               cnt_reg    <= '0;
               neg_reg    <= cur_a[C_WIDTH-1] ^ cur_b[C_WIDTH-1];
            end
            ST_CALC: begin
               if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg + CNT_W'(1);
            end
            ST_WRITE: begin
               prod_mem[idx_reg] <= result_c;
               ovf_reg[idx_reg]  <= sat_c;
               if (next_found) idx_reg <= next_idx;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/tdm_mul_sched.md
TDM_MUL_SCHED -- requirements
Module: tdm_mul_sched

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, operand/product width in bits (4..32).
REQ-002 SHALL have parameter FIXED_POINT, default 8, fractional bits; FIXED_POINT < C_WIDTH.
REQ-003 SHALL have parameter NUM_UNITS, default 32, channel count (2..65536); index width = CLOG2(NUM_UNITS).
REQ-004 SHALL have port ctl_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port ctl_rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port frame_start  in  1  single-cycle request to process one frame.
REQ-007 SHALL have port ch_enable  in  NUM_UNITS  per-channel enable mask, sampled with frame_start.
REQ-008 SHALL have port multiplicands  in  C_WIDTH*NUM_UNITS  channel i operand a at bits [C_WIDTH*(i+1)-1:C_WIDTH*i].
REQ-009 SHALL have port multipliers  in  C_WIDTH*NUM_UNITS  channel i operand b, same packing.
REQ-010 SHALL have port products  out  C_WIDTH*NUM_UNITS  registered channel results, same packing.
REQ-011 SHALL have port ovf_flags  out  NUM_UNITS  registered per-channel saturation flags.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse at frame completion.
REQ-014 SHALL have port overrun  out  1  one-cycle pulse when frame_start is rejected.

Function
REQ-015 SHALL compute per channel: signed two's-complement fixed-point y = sign(a)*sign(b)*floor(|a|*|b| / 2^FIXED_POINT), with truncation toward zero.
REQ-016 SHALL form |a| and |b| as C_WIDTH-bit unsigned magnitudes, so -2^(C_WIDTH-1) gives magnitude 2^(C_WIDTH-1); the full product SHALL be 2*C_WIDTH bits wide.
REQ-017 SHALL saturate when the truncated magnitude exceeds 2^(C_WIDTH-1)-1: the result becomes +(2^(C_WIDTH-1)-1) or -(2^(C_WIDTH-1)-1) by sign, and the channel ovf flag is set to 1.
REQ-018 SHALL clear the ovf flag to 0 on a non-saturating result; a zero product SHALL give 0 with a positive sign.
REQ-019 SHALL implement states IDLE, LOAD, CALC, WRITE, DONE using a single shared radix-2 shift-add multiplier core.
REQ-020 IDLE: on frame_start with at least one ch_enable bit set, SHALL latch the mask and go to LOAD at the lowest enabled index.
REQ-021 IDLE: on frame_start with an all-zero mask, SHALL go to DONE; products and flags SHALL be unchanged.
REQ-022 LOAD (1 cycle): SHALL capture the magnitudes and the sign of the current channel's operands.
REQ-023 CALC: SHALL run exactly C_WIDTH cycles, one multiplier bit per cycle.
REQ-024 WRITE (1 cycle): SHALL register the result and ovf flag into the current channel only.
REQ-024a After WRITE, SHALL go to LOAD at the next higher enabled index (skipping disabled channels), or to DONE if none remain.
REQ-025 DONE (1 cycle): SHALL assert frame_done, then return to IDLE.
REQ-026 SHALL take C_WIDTH+2 cycles per enabled channel; frame_done SHALL assert exactly N_en*(C_WIDTH+2)+1 cycles after the edge that samples frame_start, where N_en is the number of enabled channels.
REQ-027 Disabled channels SHALL hold their previous products and ovf_flags.
REQ-028 Operands SHALL be sampled only in the channel's LOAD cycle; changes at any other time SHALL NOT affect that channel.
REQ-029 frame_start while busy=1 SHALL be ignored and SHALL produce an overrun pulse on the next cycle; this includes frame_start in the DONE cycle.
REQ-030 A ch_enable change while busy SHALL have no effect on the current frame.
REQ-031 frame_start in the cycle after DONE (state IDLE) SHALL be accepted normally.

Reset
REQ-032 While ctl_rst=0, the state SHALL be IDLE and products, ovf_flags, busy, frame_done, overrun and all internal registers SHALL be 0, immediately and without a clock.
REQ-033 Reset asserted mid-frame SHALL abort the frame, with no further writes and no frame_done.
REQ-034 After deassertion, the first accepted frame_start SHALL be on the first rising edge at which ctl_rst=1.

Verification (bench: C_WIDTH=16, FIXED_POINT=8, NUM_UNITS=4)
REQ-035 Ch0 a=0x0180, b=0x0200; ch1 a=0xFE80, b=0x0200; mask 4'b0011 -> products ch0=0x0300, ch1=0xFD00, ovf=0; frame_done 37 cycles after the frame_start edge.
REQ-036 Ch2 a=0x7F00, b=0x0200 -> ch2=0x7FFF, ovf[2]=1; ch3 a=0x8100, b=0x0200 -> ch3=0x8001, ovf[3]=1; a following frame with ch2 a=0x0100, b=0x0100 -> ch2=0x0100, ovf[2]=0.
REQ-037 Mask 4'b0101 with distinct operands -> only ch0 and ch2 update, ch1 and ch3 hold prior values; busy high 37 cycles.
REQ-038 Mask 0 -> frame_done pulse on the cycle after frame_start, all outputs unchanged; frame_start at busy cycle 10 -> overrun pulse, frame result and timing unchanged.
REQ-039 ctl_rst low at CALC cycle 5 of ch1 -> all outputs 0 asynchronously, no frame_done; a new frame after release completes normally.
